frame_scheduler: RTL

//  Sequences one Ethernet test frame per period. Each frame: patch a 32-bit payload word
//  big-endian into the packet BRAM write port, pulse start to eth_tx2, then track tx_busy
//  to completion. The payload word comes from a host valid/ready port or an internal

---
 rtl/frame_sched_pkg.sv | 29 ++
 rtl/frame_sched_if.sv | 30 +++
 rtl/frame_sched_timer.sv | 30 +++
 rtl/frame_scheduler.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/frame_sched_pkg.sv
// frame_sched_pkg: shared types and sizing helpers for frame_scheduler.
//   state_t         scheduler FSM states
//   BYTES_PER_WORD  payload bytes patched per frame
//   timer_w()       width of the shared period/timeout down-counter
package frame_sched_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_PERIOD,
    ST_WRITE,
    ST_START,
    ST_WAIT_HI,
    ST_WAIT_LO
  } state_t;

  localparam int BYTES_PER_WORD   = 4;
  localparam int PERIOD_DEF       = 2097152;
  localparam int BUSY_TIMEOUT_DEF = 4095;

  // The timeout path reloads the full PERIOD (not PERIOD-1), so the counter
  // must hold max(PERIOD, BUSY_TIMEOUT) itself, hence the +1.
  function automatic int timer_w(input int period, input int timeout);
    int m;
    m = (period > timeout) ? period : timeout;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

  localparam int TIMER_W = timer_w(PERIOD_DEF, BUSY_TIMEOUT_DEF);

endpackage

// File: rtl/frame_sched_if.sv
// frame_sched_if: host word port, BRAM write port and eth_tx2 handshake.
//   master: the scheduler side (drives word_ready, bram_*, tx_start,
//           frame_count, tx_err; receives word_valid/word_data, tx_busy)
//   slave : host / BRAM / transmitter side
interface frame_sched_if #(
  parameter int ADDR_W = 10
);
  logic              word_valid;
  logic [31:0]       word_data;
  logic              word_ready;
  logic              bram_wr_en;
  logic [ADDR_W-1:0] bram_wr_addr;
  logic [7:0]        bram_wr_data;
  logic              tx_start;
  logic              tx_busy;
  logic [31:0]       frame_count;
  logic              tx_err;

  modport master (
    input  word_valid, word_data, tx_busy,
    output word_ready, bram_wr_en, bram_wr_addr, bram_wr_data,
           tx_start, frame_count, tx_err
  );

  modport slave (
    output word_valid, word_data, tx_busy,
    input  word_ready, bram_wr_en, bram_wr_addr, bram_wr_data,
           tx_start, frame_count, tx_err
  );
endinterface

// File: rtl/frame_sched_timer.sv
// frame_sched_timer: loadable down-counter shared by the period and the
// busy-timeout phases. Saturates at zero.
//   clk, rst (async, high), clk_en  - advance only when clk_en=1
//   load, load_val                  - load has priority over dec
//   dec                             - decrement by one (stops at 0)
//   zero                            - count == 0
module frame_sched_timer #(
  parameter int            W       = 8,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clk_en,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        count <= RST_VAL;
    else if (clk_en) begin
      if (load)                     count <= load_val;
      else if (dec && count != '0)  count <= count - W'(1);
    end
  end

  assign zero = (count == '0);
endmodule

// File: rtl/frame_scheduler.sv
// frame_scheduler: one Ethernet test frame per period. Patches a 32-bit
// payload word big-endian into the packet BRAM, pulses tx_start to eth_tx2,
// then tracks tx_busy to completion.
//   clk, rst (async, high), clk_en (all state qualified by it)
//   bus (frame_sched_if.master): host word valid/ready, BRAM write port,
//       tx_start/tx_busy, frame_count, sticky tx_err
// Build option FRAME_SCHED_AUTOINC_EN: idle periods are filled with an
// internal sequence word; without it the block waits at timer=0 for a host word.
module frame_scheduler
  import frame_sched_pkg::*;
#(
  parameter int                ADDR_W       = 10,
  parameter logic [ADDR_W-1:0] PAYLOAD_ADDR = 10'h038,
  parameter int                PERIOD       = PERIOD_DEF,
  parameter int                BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_en,
  frame_sched_if.master bus
);
  localparam int TW = timer_w(PERIOD, BUSY_TIMEOUT);
  localparam int BW = $clog2(BYTES_PER_WORD);

  state_t            state, state_d;
  logic [BW-1:0]     b, b_d;
  logic [31:0]       word, word_d, held, held_d, fc_d;
  logic              pending, pending_d, capture, err_d;
  logic              t_load, t_dec, t_zero;
  logic [TW-1:0]     t_val;
  logic              wr_en_d, start_d;
  logic [ADDR_W-1:0] addr_d;
  logic [7:0]        data_d;
`ifdef FRAME_SCHED_AUTOINC_EN
  logic [31:0]       seq, seq_d;
`endif

  frame_sched_timer #(.W(TW), .RST_VAL(TW'(PERIOD - 1))) u_timer (
    .clk, .rst, .clk_en,
    .load(t_load), .dec(t_dec), .load_val(t_val), .zero(t_zero)
  );

  assign capture        = bus.word_valid & ~pending;
  assign bus.word_ready = ~pending;

  always_comb begin
    state_d   = state;
    b_d       = b;
    word_d    = word;
    held_d    = held;
    pending_d = pending;
    fc_d      = bus.frame_count;
    err_d     = bus.tx_err;
    t_load    = 1'b0;
    t_dec     = 1'b0;
    t_val     = '0;
`ifdef FRAME_SCHED_AUTOINC_EN
    seq_d     = seq;
`endif
    // Host capture is independent of the frame phase; a held word waits
    // for the next period boundary.
    if (capture) begin
      pending_d = 1'b1;
      held_d    = bus.word_data;
    end

    unique case (state)
      ST_WAIT_PERIOD: begin
        if (!t_zero) t_dec = 1'b1;
        else if (pending) begin
          word_d = held; pending_d = 1'b0;
          state_d = ST_WRITE; b_d = '0;
        end else if (capture) begin
          // same-cycle offer goes straight into the frame, never held
          word_d = bus.word_data; pending_d = 1'b0; held_d = held;
          state_d = ST_WRITE; b_d = '0;
        end
`ifdef FRAME_SCHED_AUTOINC_EN
        else begin
          word_d = seq; seq_d = seq + 32'd1;
          state_d = ST_WRITE; b_d = '0;
        end
`endif
      end
      ST_WRITE: begin
        if (b == BW'(BYTES_PER_WORD - 1)) begin
          state_d = ST_START;
          t_load  = 1'b1;
          t_val   = TW'(BUSY_TIMEOUT);
        end else b_d = b + BW'(1);
      end
      ST_START: begin
        t_dec   = 1'b1;
        state_d = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (bus.tx_busy) state_d = ST_WAIT_LO;
        else if (t_zero) begin
          err_d   = 1'b1;
          t_load  = 1'b1;
          t_val   = TW'(PERIOD);
          state_d = ST_WAIT_PERIOD;
        end else t_dec = 1'b1;
      end
      ST_WAIT_LO: begin
        if (!bus.tx_busy) begin
          fc_d    = bus.frame_count + 32'd1;
          t_load  = 1'b1;
          t_val   = TW'(PERIOD - 1);
          state_d = ST_WAIT_PERIOD;
        end
      end
      default: state_d = ST_WAIT_PERIOD;
    endcase

    // Outputs are registered from the next state so they line up with it.
    wr_en_d = (state_d == ST_WRITE);
    start_d = (state_d == ST_START);
    addr_d  = PAYLOAD_ADDR + ADDR_W'(b_d);
    data_d  = word_d[8*(BYTES_PER_WORD - 1 - int'(b_d)) +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_WAIT_PERIOD;
      b                <= '0;
      word             <= '0;
      held             <= '0;
      pending          <= 1'b0;
      bus.bram_wr_en   <= 1'b0;
      bus.bram_wr_addr <= '0;
      bus.bram_wr_data <= '0;
      bus.tx_start     <= 1'b0;
      bus.frame_count  <= '0;
      bus.tx_err       <= 1'b0;
    end else if (clk_en) begin
      state           <= state_d;
      b               <= b_d;
      word            <= word_d;
      held            <= held_d;
      pending         <= pending_d;
      bus.bram_wr_en  <= wr_en_d;
      bus.tx_start    <= start_d;
      bus.frame_count <= fc_d;
      bus.tx_err      <= err_d;
      if (wr_en_d) begin
        bus.bram_wr_addr <= addr_d;
        bus.bram_wr_data <= data_d;
      end
    end
  end

`ifdef FRAME_SCHED_AUTOINC_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         seq <= '0;
    else if (clk_en) seq <= seq_d;
  end
`endif

endmodule
